// File: rtl/dmem_pkg.sv
// Shared size codes, FSM encoding and error classification for the data-memory responder.
// The DMEM_MISALIGN_CHECK_EN build option only changes how dmem_responder computes 'misaligned'.
package dmem_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE           = 3'd0,
        ERR_RANGE          = 3'd1,
        ERR_SIZE           = 3'd2,
        ERR_STORE_UNSIGNED = 3'd3,
        ERR_MISALIGN       = 3'd4
    } err_cause_t;

    // Highest-priority fault wins; any cause other than ERR_NONE suppresses the write.
    function automatic err_cause_t err_cause(input logic       in_range,
                                             input logic       we,
                                             input logic [2:0] size,
                                             input logic       misaligned);
        err_cause_t cause;
        logic       legal_size;
        cause = ERR_NONE;
        case (size)
            SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: legal_size = 1'b1;
            default:                        legal_size = 1'b0;
        endcase
        if (!in_range)
            cause = ERR_RANGE;
        else if (!legal_size)
            cause = ERR_SIZE;
        else if (we && (size == SZ_BU || size == SZ_HU))
            cause = ERR_STORE_UNSIGNED;
        else if (misaligned)
            cause = ERR_MISALIGN;
        return cause;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian byte-lane steering: load extraction/extension and store merge for one word.
// Offsets are always forced to natural alignment; misalignment faults are decided elsewhere.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] stored_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_value,
    output logic [31:0] store_word,
    output logic [3:0]  lane_en
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] replicated;

    always_comb begin
        sel_byte = stored_word[{addr_lo, 3'b000} +: 8];
        sel_half = addr_lo[1] ? stored_word[31:16] : stored_word[15:0];

        case (size)
            SZ_B:    load_value = {{24{sel_byte[7]}}, sel_byte};
            SZ_BU:   load_value = {24'h000000, sel_byte};
            SZ_H:    load_value = {{16{sel_half[15]}}, sel_half};
            SZ_HU:   load_value = {16'h0000, sel_half};
            SZ_W:    load_value = stored_word;
            default: load_value = 32'h0000_0000;
        endcase
    end

    // Replicate the store data across the word so each enabled lane just picks its own byte.
    always_comb begin
        case (size)
            SZ_B, SZ_BU: begin
                lane_en    = 4'b0001 << addr_lo;
                replicated = {4{wdata[7:0]}};
            end
            SZ_H, SZ_HU: begin
                lane_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                replicated = {2{wdata[15:0]}};
            end
            SZ_W: begin
                lane_en    = 4'b1111;
                replicated = wdata;
            end
            default: begin
                lane_en    = 4'b0000;
                replicated = 32'h0000_0000;
            end
        endcase

        store_word = stored_word;
        for (int i = 0; i < 4; i++) begin
            if (lane_en[i])
                store_word[8*i +: 8] = replicated[8*i +: 8];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, fixed wait latency, valid/ready on both sides.
// Define DMEM_MISALIGN_CHECK_EN to fault misaligned half/word accesses instead of aligning them.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] LOAD_COUNT = (LATENCY > 0) ? CW'(LATENCY - 1) : '0;

    state_t        state;
    logic [CW-1:0] count;

    logic          lat_we;
    logic [31:0]   lat_addr;
    logic [2:0]    lat_size;
    logic [31:0]   lat_wdata;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          op_we;
    logic [31:0]   op_addr;
    logic [2:0]    op_size;
    logic [31:0]   op_wdata;
    logic [AW-1:0] word_idx;
    logic          in_range;
    logic          misaligned;
    logic          has_err;
    logic          accept;
    logic          commit;
    logic [31:0]   stored_word;
    logic [31:0]   load_value;
    logic [31:0]   store_word;
    logic [3:0]    lane_en;
    logic [31:0]   rdata_next;

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // With zero latency the commit happens on the acceptance edge, before the latch holds the request.
    always_comb begin
        if (state == IDLE) begin
            op_we    = req_we;
            op_addr  = req_addr;
            op_size  = req_size;
            op_wdata = req_wdata;
        end else begin
            op_we    = lat_we;
            op_addr  = lat_addr;
            op_size  = lat_size;
            op_wdata = lat_wdata;
        end
    end

    assign word_idx    = op_addr[AW+1:2];
    assign in_range    = ({2'b00, op_addr[31:2]} < 32'(DEPTH_WORDS));
    assign stored_word = mem[word_idx];

`ifdef DMEM_MISALIGN_CHECK_EN
    always_comb begin
        case (op_size)
            SZ_H, SZ_HU: misaligned = op_addr[0];
            SZ_W:        misaligned = |op_addr[1:0];
            default:     misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    assign has_err    = (err_cause(in_range, op_we, op_size, misaligned) != ERR_NONE);
    assign rdata_next = (has_err || op_we) ? 32'h0000_0000 : load_value;
    assign commit     = ((state == BUSY) && (count == '0)) || ((LATENCY == 0) && accept);

    dmem_lane_align u_lane_align (
        .size        (op_size),
        .addr_lo     (op_addr[1:0]),
        .stored_word (stored_word),
        .wdata       (op_wdata),
        .load_value  (load_value),
        .store_word  (store_word),
        .lane_en     (lane_en)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
            rsp_error <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= 32'h0000_0000;
            lat_size  <= 3'b000;
            lat_wdata <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_we    <= req_we;
                        lat_addr  <= req_addr;
                        lat_size  <= req_size;
                        lat_wdata <= req_wdata;
                        if (LATENCY == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rdata_next;
                            rsp_error <= has_err;
                        end else begin
                            state <= BUSY;
                            count <= LOAD_COUNT;
                        end
                    end
                end
                BUSY: begin
                    if (count == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rdata_next;
                        rsp_error <= has_err;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'h0000_0000;
                        rsp_error <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The array has no reset; a commit can only occur outside reset because reset holds the FSM in IDLE.
    always_ff @(posedge clock) begin
        if (commit && op_we && !has_err) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i])
                    mem[word_idx][8*i +: 8] <= store_word[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver queues expected responses, a monitor checks them.
// Misalignment expectations follow DMEM_MISALIGN_CHECK_EN.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH_WORDS = 256;
    localparam int LATENCY     = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    typedef struct {
        logic [31:0] rdata;
        logic        error;
        logic [31:0] accept_cycle;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          assertions = 0;
    int          failures   = 0;
    logic [31:0] cycle      = 32'd0;

    logic        seen_valid = 1'b0;
    logic        idle_check = 1'b0;
    logic [31:0] snap_rdata;
    logic        snap_error;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .LATENCY     (LATENCY)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 32'd1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: checks latency on the first valid cycle, stability while stalled, and data on handshake.
    always @(negedge clock) begin
        if (reset) begin
            seen_valid = 1'b0;
            idle_check = 1'b0;
        end else begin
            if (idle_check) begin
                checkOutput("valid_cleared_after_handshake", {31'd0, rsp_valid}, 32'd0);
                checkOutput("req_ready_after_handshake", {31'd0, req_ready}, 32'd1);
                idle_check = 1'b0;
            end
            if (rsp_valid) begin
                checkOutput("req_ready_low_in_resp", {31'd0, req_ready}, 32'd0);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_response", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    if (!seen_valid) begin
                        seen_valid = 1'b1;
                        snap_rdata = rsp_rdata;
                        snap_error = rsp_error;
                        checkOutput({exp_q[0].name, "_latency"},
                                    cycle - exp_q[0].accept_cycle + 32'd1, 32'(LATENCY + 1));
                    end else begin
                        checkOutput({exp_q[0].name, "_stable_rdata"}, rsp_rdata, snap_rdata);
                        checkOutput({exp_q[0].name, "_stable_error"}, {31'd0, rsp_error}, {31'd0, snap_error});
                    end
                    if (rsp_ready) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        checkOutput({e.name, "_rdata"}, rsp_rdata, e.rdata);
                        checkOutput({e.name, "_error"}, {31'd0, rsp_error}, {31'd0, e.error});
                        seen_valid = 1'b0;
                        idle_check = 1'b1;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input string name, input logic we, input logic [31:0] addr,
                                 input logic [2:0] size, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic exp_err, input bit track);
        int waited;
        @(negedge clock);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wdata;
        waited    = 0;
        while (!req_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (!req_ready) begin
            checkOutput({name, "_accept_timeout"}, {31'd0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        if (track)
            exp_q.push_back('{exp_rdata, exp_err, cycle + 32'd1, name});
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic waitResponse();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            checkOutput("response_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic waitValid(input string name);
        int n;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!rsp_valid)
            checkOutput({name, "_valid_timeout"}, {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic runTxn(input string name, input logic we, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        applyStimulus(name, we, addr, size, wdata, exp_rdata, exp_err, 1'b1);
        waitResponse();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_size  = SZ_W;
        req_wdata = 32'h0;
        rsp_ready = 1'b1;

        repeat (3) @(negedge clock);
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd0);
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset_rsp_error", {31'd0, rsp_error}, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("req_ready_after_init", {31'd0, req_ready}, 32'd1);

        runTxn("st_w_10",     1'b1, 32'h10,  SZ_W,  32'hDEADBEEF, 32'h0,        1'b0);
        runTxn("ld_w_10",     1'b0, 32'h10,  SZ_W,  32'h0,        32'hDEADBEEF, 1'b0);
        runTxn("ld_b_13",     1'b0, 32'h13,  SZ_B,  32'h0,        32'hFFFFFFDE, 1'b0);
        runTxn("ld_bu_13",    1'b0, 32'h13,  SZ_BU, 32'h0,        32'h000000DE, 1'b0);
        runTxn("ld_hu_12",    1'b0, 32'h12,  SZ_HU, 32'h0,        32'h0000DEAD, 1'b0);
        runTxn("ld_h_10",     1'b0, 32'h10,  SZ_H,  32'h0,        32'hFFFFBEEF, 1'b0);
        runTxn("st_b_11",     1'b1, 32'h11,  SZ_B,  32'hAAAAAA55, 32'h0,        1'b0);
        runTxn("ld_w_10_b",   1'b0, 32'h10,  SZ_W,  32'h0,        32'hDEAD55EF, 1'b0);
        runTxn("st_h_16",     1'b1, 32'h16,  SZ_H,  32'h1234ABCD, 32'h0,        1'b0);
        runTxn("ld_hu_16",    1'b0, 32'h16,  SZ_HU, 32'h0,        32'h0000ABCD, 1'b0);
        runTxn("ld_b_17",     1'b0, 32'h17,  SZ_B,  32'h0,        32'hFFFFFFAB, 1'b0);

        runTxn("st_w_00",     1'b1, 32'h0,   SZ_W,  32'hCAFEF00D, 32'h0,        1'b0);
        runTxn("ld_w_400",    1'b0, 32'h400, SZ_W,  32'h0,        32'h0,        1'b1);
        runTxn("st_w_400",    1'b1, 32'h400, SZ_W,  32'h11111111, 32'h0,        1'b1);
        runTxn("ld_w_00",     1'b0, 32'h0,   SZ_W,  32'h0,        32'hCAFEF00D, 1'b0);
        runTxn("ld_sz011",    1'b0, 32'h10,  3'b011, 32'h0,       32'h0,        1'b1);
        runTxn("st_sz111",    1'b1, 32'h10,  3'b111, 32'h01020304, 32'h0,       1'b1);
        runTxn("st_bu_10",    1'b1, 32'h10,  SZ_BU, 32'h00000077, 32'h0,        1'b1);
        runTxn("st_hu_10",    1'b1, 32'h10,  SZ_HU, 32'h00007777, 32'h0,        1'b1);
        runTxn("ld_w_10_c",   1'b0, 32'h10,  SZ_W,  32'h0,        32'hDEAD55EF, 1'b0);

`ifdef DMEM_MISALIGN_CHECK_EN
        runTxn("ld_w_12_mis", 1'b0, 32'h12,  SZ_W,  32'h0,        32'h0,        1'b1);
        runTxn("ld_h_13_mis", 1'b0, 32'h13,  SZ_H,  32'h0,        32'h0,        1'b1);
        runTxn("st_w_12_mis", 1'b1, 32'h12,  SZ_W,  32'h0BADF00D, 32'h0,        1'b1);
`else
        runTxn("ld_w_12_aln", 1'b0, 32'h12,  SZ_W,  32'h0,        32'hDEAD55EF, 1'b0);
        runTxn("ld_h_13_aln", 1'b0, 32'h13,  SZ_H,  32'h0,        32'hFFFFDEAD, 1'b0);
        runTxn("st_w_12_aln", 1'b1, 32'h12,  SZ_W,  32'h0BADF00D, 32'h0,        1'b0);
        runTxn("st_w_10_rst", 1'b1, 32'h10,  SZ_W,  32'hDEAD55EF, 32'h0,        1'b0);
`endif
        runTxn("ld_w_10_d",   1'b0, 32'h10,  SZ_W,  32'h0,        32'hDEAD55EF, 1'b0);

        $display("[TB] stalling response for 5 cycles");
        rsp_ready = 1'b0;
        applyStimulus("ld_w_10_stall", 1'b0, 32'h10, SZ_W, 32'h0, 32'hDEAD55EF, 1'b0, 1'b1);
        waitValid("ld_w_10_stall");
        repeat (5) @(negedge clock);
        rsp_ready = 1'b1;
        waitResponse();

        runTxn("st_w_20_zero", 1'b1, 32'h20, SZ_W, 32'h00000000, 32'h0, 1'b0);

        $display("[TB] reset during BUSY of store to 0x20");
        applyStimulus("st_w_20_abort", 1'b1, 32'h20, SZ_W, 32'h12345678, 32'h0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("abort_req_ready_in_reset", {31'd0, req_ready}, 32'd0);
        checkOutput("abort_rsp_valid_in_reset", {31'd0, rsp_valid}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("abort_req_ready_after_reset", {31'd0, req_ready}, 32'd1);
        runTxn("ld_w_20_after_abort", 1'b0, 32'h20, SZ_W, 32'h0, 32'h00000000, 1'b0);

        $display("[TB] reset during RESP of committed store to 0x24");
        rsp_ready = 1'b0;
        applyStimulus("st_w_24_commit", 1'b1, 32'h24, SZ_W, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1);
        waitValid("st_w_24_commit");
        @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset     = 1'b0;
        rsp_ready = 1'b1;
        runTxn("ld_w_24_after_reset", 1'b0, 32'h24, SZ_W, 32'h0, 32'hA5A5A5A5, 1'b0);
        runTxn("ld_b_26_after_reset", 1'b0, 32'h26, SZ_B, 32'h0, 32'hFFFFFFA5, 1'b0);

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
